// File: rtl/led_chaser_multi_pkg.sv
// Shared mode and direction encodings for the LED chaser.
// Only MODE values and the ping-pong direction live here.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL = 2'd0,
        MODE_ROTR = 2'd1,
        MODE_PING = 2'd2,
        MODE_FILL = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_chaser_multi_ms_tick_gen.sv
// Millisecond prescaler: tick is high for one cycle every TICK_DIV enabled cycles.
// Combinational tick from registered count; EN=0 freezes the count, clr restarts it.
module ms_tick_gen #(
    parameter int TICK_DIV = 50_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic clr,
    output logic tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;

    assign tick = EN && (tick_cnt_q == LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clr) begin
            tick_cnt_d = '0;
        end else if (EN) begin
            tick_cnt_d = (tick_cnt_q == LAST) ? '0 : tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/led_chaser_multi.sv
// LED pattern generator: steps N_LED outputs every max(STEP_MS,1) ms in one of four modes.
// LED_Out/STEP_Pulse registered one edge after the step decision; EN=0 freezes everything.
module led_chaser_multi
    import led_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 50_000,
    parameter int STEP_W   = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic [STEP_W-1:0] STEP_MS,
    output logic [N_LED-1:0]  LED_Out,
    output logic              STEP_Pulse
);

    localparam logic [N_LED-1:0] ONE = N_LED'(1);

    mode_e             mode_q;
    dir_e              dir_q, dir_d;
    logic [N_LED-1:0]  led_q, led_d;
    logic [N_LED-1:0]  rotl, rotr;
    logic [STEP_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [STEP_W-1:0] period_m1;
    logic              pulse_q;
    logic              tick;
    logic              step;
    logic              mode_chg;
    logic              onehot;

    assign mode_chg = (MODE != mode_q);

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .clr  (mode_chg),
        .tick (tick)
    );

    // >= rather than == so lowering STEP_MS below the running count steps on the next tick.
    assign period_m1 = (STEP_MS == '0) ? '0 : STEP_MS - STEP_W'(1);
    assign step      = tick && (ms_cnt_q >= period_m1);

    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if (tick) begin
            ms_cnt_d = step ? '0 : ms_cnt_q + STEP_W'(1);
        end
    end

    always_comb begin
        rotl = '0;
        rotr = '0;
        for (int i = 0; i < N_LED; i++) begin
            rotl[i] = led_q[(i + N_LED - 1) % N_LED];
            rotr[i] = led_q[(i + 1) % N_LED];
        end
    end

    assign onehot = $onehot(led_q);

    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        case (mode_q)
            MODE_ROTL: led_d = onehot ? rotl : ONE;
            MODE_ROTR: led_d = onehot ? rotr : ONE;
            MODE_PING: begin
                if (!onehot || N_LED == 1) begin
                    led_d = ONE;
                    dir_d = DIR_UP;
                end else if (dir_q == DIR_UP) begin
                    // Turning at an end moves immediately, so each end bit dwells one step.
                    if (led_q[N_LED-1]) begin
                        led_d = led_q >> 1;
                        dir_d = DIR_DN;
                    end else begin
                        led_d = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        led_d = led_q << 1;
                        dir_d = DIR_UP;
                    end else begin
                        led_d = led_q >> 1;
                    end
                end
            end
            MODE_FILL: begin
                if (&led_q) begin
                    led_d = '0;
                end else if (led_q == '0) begin
                    led_d = ONE;
                end else begin
                    led_d = (led_q << 1) | ONE;
                end
            end
            default: led_d = led_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || mode_chg) begin
            mode_q   <= mode_e'(MODE);
            led_q    <= ONE;
            dir_q    <= DIR_UP;
            ms_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q  <= step;
            ms_cnt_q <= ms_cnt_d;
            if (step) begin
                led_q <= led_d;
                dir_q <= dir_d;
            end
        end
    end

    assign LED_Out    = led_q;
    assign STEP_Pulse = pulse_q;

endmodule
